// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with registered result and NZCV flags.
// Logic ops, ADD/ADC/SUB/SBC and signed SLT complete one cycle after acceptance.
// MUL is an iterative shift-add that takes WIDTH steps.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_valid / in_ready               operand bundle handshake
//   operand_a, operand_b              operands (WIDTH bits)
//   alu_control                       4-bit operation select
//   carry_in                          CPSR C flag for ADC, SBC and pass-through
//   out_valid / out_ready             result bundle handshake
//   result, flag_n/z/c/v, op_error    registered result, flags, reserved-op flag
module alu_mc #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [3:0]       alu_control,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             op_error
);

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_ORR = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_SLT = 4'h4;
   localparam logic [3:0] OP_MUL = 4'h5;
   localparam logic [3:0] OP_EOR = 4'h6;
   localparam logic [3:0] OP_ADC = 4'h7;
   localparam logic [3:0] OP_SBC = 4'h8;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
   logic             cin_q, cin_d;
   logic [WIDTH-1:0] result_d;
   logic             n_d, z_d, c_d, v_d, err_d, in_ready_d, out_valid_d;

   logic             is_sub, sum_cin;
   logic [WIDTH-1:0] b_eff, alu_res, mul_step;
   logic [WIDTH:0]   sum;
   logic             alu_c, alu_v, alu_err;

   // Single-cycle ops evaluated on the live inputs; used only on the accept cycle.
   // Subtraction is a + ~b + cin, so the carry-out is NOT borrow.
   always_comb begin
      is_sub  = (alu_control == OP_SUB) || (alu_control == OP_SBC);
      b_eff   = is_sub ? ~operand_b : operand_b;
      unique case (alu_control)
         OP_ADC, OP_SBC: sum_cin = carry_in;
         OP_SUB:         sum_cin = 1'b1;
         default:        sum_cin = 1'b0;
      endcase
      sum = {1'b0, operand_a} + {1'b0, b_eff} + (WIDTH+1)'(sum_cin);

      alu_res = '0;
      alu_c   = carry_in;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (alu_control)
         OP_AND: alu_res = operand_a & operand_b;
         OP_ORR: alu_res = operand_a | operand_b;
         OP_EOR: alu_res = operand_a ^ operand_b;
         OP_SLT: alu_res = WIDTH'($signed(operand_a) < $signed(operand_b));
         OP_MUL: alu_res = '0;
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (operand_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (sum[WIDTH-1] != operand_a[WIDTH-1]);
         end
         default: begin
            alu_c   = 1'b0;
            alu_err = 1'b1;
         end
      endcase
   end

   assign mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cin_d       = cin_q;
      result_d    = result;
      n_d         = flag_n;
      z_d         = flag_z;
      c_d         = flag_c;
      v_d         = flag_v;
      err_d       = op_error;
      in_ready_d  = in_ready;
      out_valid_d = out_valid;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               cin_d      = carry_in;
               in_ready_d = 1'b0;
               if (alu_control == OP_MUL) begin
                  acc_d    = '0;
                  mcand_d  = operand_a;
                  mplier_d = operand_b;
                  cnt_d    = '0;
                  state_d  = S_BUSY;
               end else begin
                  result_d    = alu_res;
                  n_d         = alu_res[WIDTH-1];
                  z_d         = (alu_res == '0);
                  c_d         = alu_c;
                  v_d         = alu_v;
                  err_d       = alu_err;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end
            end
         end
         S_BUSY: begin
            acc_d    = mul_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               result_d    = mul_step;
               n_d         = mul_step[WIDTH-1];
               z_d         = (mul_step == '0);
               c_d         = cin_q;
               v_d         = 1'b0;
               err_d       = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cin_q     <= 1'b0;
         result    <= '0;
         flag_n    <= 1'b0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         flag_v    <= 1'b0;
         op_error  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cin_q     <= cin_d;
         result    <= result_d;
         flag_n    <= n_d;
         flag_z    <= z_d;
         flag_c    <= c_d;
         flag_v    <= v_d;
         op_error  <= err_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=32): the driver pushes hand-computed
// expectations on acceptance, the monitor pops and compares on each output handshake.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] operand_a, operand_b;
   logic [3:0]  alu_control;
   logic        carry_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        flag_n, flag_z, flag_c, flag_v, op_error;

   typedef struct packed {
      logic [31:0] r;
      logic        n, z, c, v, e;
      logic [31:0] lat;
      logic [31:0] acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_acc = 0;

   alu_mc #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .operand_a(operand_a), .operand_b(operand_b), .alu_control(alu_control),
      .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
      .flag_v(flag_v), .op_error(op_error)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic exp_t mk(input logic [31:0] r, input logic n, z, c, v, e,
                               input int lat);
      exp_t x;
      x.r = r; x.n = n; x.z = z; x.c = c; x.v = v; x.e = e;
      x.lat = 32'(lat); x.acc = '0;
      return x;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Issue one bundle, hold it until accepted, then scramble the inputs.
   task automatic send(input logic [3:0] op, input logic [31:0] a, b,
                       input logic cin, input exp_t e);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; alu_control = op; operand_a = a; operand_b = b; carry_in = cin;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stayed 0 for op %h", op);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e.acc = 32'(cyc);
      last_acc = cyc;
      sb.push_back(e);
      in_valid = 1'b0; operand_a = 32'h5A5A_A5A5; operand_b = 32'h1234_5678;
      alu_control = 4'h2; carry_in = ~cin;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: compare on every output handshake.
   initial begin
      exp_t e;
      bit   seen = 0;
      int   rise = 0;
      forever begin
         @(negedge clk);
         if (!out_valid) seen = 0;
         else if (!seen) begin
            seen = 1;
            rise = cyc;
         end
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: result %h with empty scoreboard", result);
            end else begin
               e = sb.pop_front();
               check("result_flags", {27'd0, result, flag_n, flag_z, flag_c, flag_v, op_error},
                     {27'd0, e.r, e.n, e.z, e.c, e.v, e.e});
               check("latency", 64'(32'(rise) - e.acc), 64'(e.lat));
            end
         end
      end
   end

   initial begin
      exp_t junk;
      int   hs;
      int   n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      operand_a = '0; operand_b = '0; alu_control = '0; carry_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", {25'd0, in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, op_error},
            {25'd0, 1'b1, 1'b0, 32'd0, 5'b00000});
      rst_n = 1'b1;

      //   op    a             b             cin         r            n z c v e lat
      send(4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h8000_0000, 1,0,0,1,0, 0));
      send(4'h3, 32'd5,         32'd5,         1'b0, mk(32'h0000_0000, 0,1,1,0,0, 0));
      send(4'h8, 32'd5,         32'd5,         1'b0, mk(32'hFFFF_FFFF, 1,0,0,0,0, 0));
      send(4'h4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, mk(32'h0000_0001, 0,0,1,0,0, 0));
      send(4'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, mk(32'h00F0_1234, 0,0,0,0,0, 0));
      send(4'h1, 32'h8000_0000, 32'h0000_0001, 1'b1, mk(32'h8000_0001, 1,0,1,0,0, 0));
      send(4'h7, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, mk(32'h0000_0000, 0,1,1,0,0, 0));
      send(4'h3, 32'd3,         32'd5,         1'b1, mk(32'hFFFF_FFFE, 1,0,0,0,0, 0));
      send(4'h3, 32'h8000_0000, 32'h0000_0001, 1'b0, mk(32'h7FFF_FFFF, 0,0,1,1,0, 0));
      drain();

      // Back-pressure on an EOR result.
      @(negedge clk);
      out_ready = 1'b0;
      send(4'h6, 32'hAAAA_5555, 32'hFFFF_FFFF, 1'b1, mk(32'h5555_AAAA, 0,0,1,0,0, 0));
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check("backpressure_hold", {25'd0, out_valid, in_ready, result, flag_n, flag_z, flag_c, flag_v, op_error},
               {25'd0, 1'b1, 1'b0, 32'h5555_AAAA, 5'b00100});
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 hs = cyc;
      send(4'h2, 32'd1, 32'd1, 1'b0, mk(32'h0000_0002, 0,0,0,0,0, 0));
      check("accept_after_handshake", 64'(last_acc), 64'(hs + 1));
      drain();

      // MUL with ignored in_valid pulses while busy.
      send(4'h5, 32'h0001_0003, 32'h0001_0005, 1'b0, mk(32'h0008_000F, 0,0,0,0,0, 32));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1; alu_control = 4'h2; operand_a = 32'd1; operand_b = 32'd1;
         check("busy_in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
         in_valid = 1'b0;
      end
      drain();
      send(4'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk(32'h0000_0001, 0,0,1,0,0, 32));

      // Reserved codes, then a valid op that clears op_error.
      send(4'hF, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, mk(32'h0000_0000, 0,1,0,0,1, 0));
      send(4'h9, 32'h0000_0001, 32'h0000_0002, 1'b0, mk(32'h0000_0000, 0,1,0,0,1, 0));
      send(4'h0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, mk(32'h0000_FFFF, 0,0,1,0,0, 0));
      drain();

      // Reset in the middle of a MUL.
      send(4'h5, 32'd3, 32'd4, 1'b0, mk(32'd12, 0,0,0,0,0, 32));
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_mid_mul", {25'd0, in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, op_error},
            {25'd0, 1'b1, 1'b0, 32'd0, 5'b00000});
      if (sb.size() != 0) junk = sb.pop_back();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(4'h2, 32'd2, 32'd3, 1'b0, mk(32'd5, 0,0,0,0,0, 0));
      drain();
      repeat (40) @(negedge clk);
      check("no_stray_output", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
